// File: rtl/adc_cap_pkg.sv
// Shared state encoding, trigger-mode codes and default widths for the
// ADC capture controller.
package adc_cap_pkg;

    localparam int DATA_W_DEF  = 12;
    localparam int ADDR_W_DEF  = 12;
    localparam int DECIM_W_DEF = 16;

    localparam logic [1:0] TRIG_IMM   = 2'd0;
    localparam logic [1:0] TRIG_LEVEL = 2'd1;
    localparam logic [1:0] TRIG_EXT   = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/adc_capture_ctrl_trig.sv
// Trigger qualification: external-trigger synchronizer with rising-edge detect,
// and unsigned level-crossing compare on the registered ADC stream.
module adc_trig_detect
    import adc_cap_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              armed,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] level,
    input  logic [DATA_W-1:0] adc_q,
    input  logic [DATA_W-1:0] prev_q,
    input  logic              ext_trig,
    output logic              trig
);

    logic ext_s1;
    logic ext_s2;
    logic ext_s3;
    logic ext_edge;
    logic level_cross;
    logic hit;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ext_s1 <= 1'b0;
            ext_s2 <= 1'b0;
            ext_s3 <= 1'b0;
        end else begin
            ext_s1 <= ext_trig;
            ext_s2 <= ext_s1;
            ext_s3 <= ext_s2;
        end
    end

    assign ext_edge    = ext_s2 & ~ext_s3;
    assign level_cross = (prev_q < level) && (adc_q >= level);

    // Mode 3 is an alias of immediate.
    always_comb begin
        hit = 1'b1;
        case (mode)
            TRIG_IMM:   hit = 1'b1;
            TRIG_LEVEL: hit = level_cross;
            TRIG_EXT:   hit = ext_edge;
            default:    hit = 1'b1;
        endcase
    end

    assign trig = armed & hit;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Sequences one triggered, decimated ADC acquisition into the capture BRAM
// and reports busy/done/over-range status.
module adc_capture_ctrl
    import adc_cap_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DECIM_W = DECIM_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  adc_data,
    input  logic               adc_otr,
    input  logic               cfg_start,
    input  logic               cfg_abort,
    input  logic [ADDR_W:0]    cfg_len,
    input  logic [DECIM_W-1:0] cfg_decim,
    input  logic [1:0]         cfg_trig_mode,
    input  logic [DATA_W-1:0]  cfg_trig_level,
    input  logic               ext_trig,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [31:0]        wr_data,
    output logic               busy,
    output logic               done,
    output logic               otr_seen,
    output logic [ADDR_W:0]    sample_cnt
);

    localparam logic [ADDR_W:0]    CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [DECIM_W-1:0] DEC_ONE = {{(DECIM_W-1){1'b0}}, 1'b1};

    cap_state_t state_q;
    cap_state_t state_d;

    logic [DATA_W-1:0]  adc_q;
    logic [DATA_W-1:0]  prev_q;
    logic               otr_q;
    logic [ADDR_W:0]    len_q;
    logic [DECIM_W-1:0] decim_q;
    logic [DECIM_W-1:0] dec_cnt;
    logic [DECIM_W-1:0] dec_next;
    logic [1:0]         mode_q;
    logic [DATA_W-1:0]  level_q;
    logic [ADDR_W:0]    cnt_inc;
    logic               trig;
    logic               start_ok;
    logic               last_wr;
    logic               dec_run;
    logic               do_start;
    logic               do_write;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            adc_q  <= '0;
            prev_q <= '0;
            otr_q  <= 1'b0;
        end else begin
            adc_q  <= adc_data;
            prev_q <= adc_q;
            otr_q  <= adc_otr;
        end
    end

    adc_trig_detect #(
        .DATA_W (DATA_W)
    ) u_trig (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .armed    (state_q == ARMED),
        .mode     (mode_q),
        .level    (level_q),
        .adc_q    (adc_q),
        .prev_q   (prev_q),
        .ext_trig (ext_trig),
        .trig     (trig)
    );

    assign start_ok = cfg_start && (cfg_len != '0);
    assign cnt_inc  = sample_cnt + CNT_ONE;
    assign last_wr  = (cnt_inc == len_q);
    assign dec_next = (dec_cnt == decim_q) ? '0 : dec_cnt + DEC_ONE;
    // The trigger cycle is decimation phase 0, so the counter advances from it onward.
    assign dec_run  = (state_q == CAPTURE) || ((state_q == ARMED) && trig);
    assign busy     = (state_q == ARMED) || (state_q == CAPTURE);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        do_start = 1'b0;
        do_write = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    do_start = 1'b1;
                    state_d  = ARMED;
                end
            end
            ARMED: begin
                if (trig) begin
                    do_write = 1'b1;
                    state_d  = last_wr ? DONE : CAPTURE;
                end
            end
            CAPTURE: begin
                if (dec_cnt == '0) begin
                    do_write = 1'b1;
                    if (last_wr) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (cfg_abort) begin
            state_d  = IDLE;
            do_start = 1'b0;
            do_write = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            done       <= 1'b0;
            otr_seen   <= 1'b0;
            sample_cnt <= '0;
            dec_cnt    <= '0;
            len_q      <= '0;
            decim_q    <= '0;
            mode_q     <= '0;
            level_q    <= '0;
        end else begin
            wr_en <= do_write;
            if (do_start) begin
                len_q      <= cfg_len;
                decim_q    <= cfg_decim;
                mode_q     <= cfg_trig_mode;
                level_q    <= cfg_trig_level;
                done       <= 1'b0;
                otr_seen   <= 1'b0;
                sample_cnt <= '0;
                dec_cnt    <= '0;
            end
            if (dec_run) begin
                dec_cnt <= dec_next;
            end
            if (do_write) begin
                wr_addr    <= sample_cnt[ADDR_W-1:0];
                wr_data    <= 32'({otr_q, adc_q});
                sample_cnt <= cnt_inc;
                if (otr_q) begin
                    otr_seen <= 1'b1;
                end
                if (last_wr) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomized bench for adc_capture_ctrl; expected BRAM writes come from a
// transaction-level model of trigger time, decimation and run length.
module tb_adc_capture_ctrl;

    localparam int SZ = 1024;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] adc_data = '0;
    logic        adc_otr = 1'b0;
    logic        cfg_start = 1'b0;
    logic        cfg_abort = 1'b0;
    logic [12:0] cfg_len = '0;
    logic [15:0] cfg_decim = '0;
    logic [1:0]  cfg_trig_mode = '0;
    logic [11:0] cfg_trig_level = '0;
    logic        ext_trig = 1'b0;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        otr_seen;
    logic [12:0] sample_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int e = 0;

    logic [11:0] samp [SZ];
    logic        otrv [SZ];
    int          wr_e_q [$];
    int          wr_a_q [$];
    logic [31:0] wr_d_q [$];

    adc_capture_ctrl dut (
        .clk_i          (clk_i),
        .rst_n          (rst_n),
        .adc_data       (adc_data),
        .adc_otr        (adc_otr),
        .cfg_start      (cfg_start),
        .cfg_abort      (cfg_abort),
        .cfg_len        (cfg_len),
        .cfg_decim      (cfg_decim),
        .cfg_trig_mode  (cfg_trig_mode),
        .cfg_trig_level (cfg_trig_level),
        .ext_trig       (ext_trig),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .busy           (busy),
        .done           (done),
        .otr_seen       (otr_seen),
        .sample_cnt     (sample_cnt)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #(1000000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Edge e samples the pins driven here as samp[e].
    task automatic step();
        @(posedge clk_i);
        #1;
        e++;
        if (wr_en) begin
            wr_e_q.push_back(e);
            wr_a_q.push_back(int'(wr_addr));
            wr_d_q.push_back(wr_data);
        end
        adc_data = samp[(e + 1) % SZ];
        adc_otr  = otrv[(e + 1) % SZ];
    endtask

    task automatic fill_rand(input int otr_pct);
        for (int i = 0; i < SZ; i++) begin
            samp[i] = 12'($urandom);
            otrv[i] = (int'($urandom_range(0, 99)) < otr_pct);
        end
    endtask

    // Ramp whose value at the upcoming start edge is v0.
    task automatic fill_ramp(input int v0);
        int s;
        s = e + 3;
        for (int k = -1; k < SZ - 1; k++) begin
            samp[(s + k) % SZ] = 12'(v0 + k);
            otrv[(s + k) % SZ] = 1'b0;
        end
    endtask

    task automatic check_outputs_zero(input string name);
        chk({name, ".wr_en"}, 64'(wr_en), 64'd0);
        chk({name, ".wr_addr"}, 64'(wr_addr), 64'd0);
        chk({name, ".wr_data"}, 64'(wr_data), 64'd0);
        chk({name, ".busy"}, 64'(busy), 64'd0);
        chk({name, ".done"}, 64'(done), 64'd0);
        chk({name, ".otr_seen"}, 64'(otr_seen), 64'd0);
        chk({name, ".sample_cnt"}, 64'(sample_cnt), 64'd0);
    endtask

    task automatic run_cap(input string name, input int mode, input int len, input int decim,
                           input int level, input int ext_at, input int ext_at2,
                           input int abort_at, input int start_at, input int ncyc);
        int s;
        int t_trig;
        int a_edge;
        int idx;
        int nmin;
        int exp_e [$];
        int exp_a [$];
        logic [31:0] exp_d [$];
        logic otr_or;

        step();
        step();
        wr_e_q.delete();
        wr_a_q.delete();
        wr_d_q.delete();
        cfg_len        = 13'(len);
        cfg_decim      = 16'(decim);
        cfg_trig_mode  = 2'(mode);
        cfg_trig_level = 12'(level);
        cfg_start      = 1'b1;
        step();
        cfg_start = 1'b0;
        s = e;
        chk({name, ".busy0"}, 64'(busy), 64'd1);
        chk({name, ".cnt0"}, 64'(sample_cnt), 64'd0);
        chk({name, ".done0"}, 64'(done), 64'd0);
        chk({name, ".otr0"}, 64'(otr_seen), 64'd0);

        for (int i = 0; i < ncyc; i++) begin
            cfg_abort = (i == abort_at);
            cfg_start = (i == start_at);
            if (i == start_at) begin
                cfg_len   = 13'd2;
                cfg_decim = '0;
            end
            ext_trig = (ext_at >= 0 && i >= ext_at && i < ext_at + 3) ||
                       (ext_at2 >= 0 && i >= ext_at2 && i < ext_at2 + 3);
            step();
        end
        cfg_abort = 1'b0;
        cfg_start = 1'b0;
        ext_trig  = 1'b0;

        // Reference: locate the trigger sample, then take every (decim+1)th sample.
        t_trig = -1;
        if (mode == 1) begin
            for (int t = s; t < s + ncyc; t++) begin
                if (samp[(t - 1) % SZ] < 12'(level) && samp[t % SZ] >= 12'(level)) begin
                    t_trig = t;
                    break;
                end
            end
        end else if (mode == 2) begin
            t_trig = (ext_at >= 0) ? s + ext_at + 2 : -1;
        end else begin
            t_trig = s;
        end
        a_edge = (abort_at >= 0) ? s + 1 + abort_at : s + ncyc + 1;
        otr_or = 1'b0;
        if (t_trig >= 0) begin
            for (int k = 0; k < len; k++) begin
                idx = t_trig + k * (decim + 1);
                if (idx + 1 > s + ncyc || idx + 1 >= a_edge) break;
                exp_e.push_back(idx + 1);
                exp_a.push_back(k);
                exp_d.push_back({19'd0, otrv[idx % SZ], samp[idx % SZ]});
                otr_or = otr_or | otrv[idx % SZ];
            end
        end

        chk({name, ".nwr"}, 64'(wr_e_q.size()), 64'(exp_e.size()));
        nmin = (wr_e_q.size() < exp_e.size()) ? wr_e_q.size() : exp_e.size();
        for (int k = 0; k < nmin; k++) begin
            chk($sformatf("%s.edge%0d", name, k), 64'(wr_e_q[k]), 64'(exp_e[k]));
            chk($sformatf("%s.addr%0d", name, k), 64'(wr_a_q[k]), 64'(exp_a[k]));
            chk($sformatf("%s.data%0d", name, k), 64'(wr_d_q[k]), 64'(exp_d[k]));
        end
        chk({name, ".done"}, 64'(done), 64'(exp_e.size() == len));
        chk({name, ".busy"}, 64'(busy), 64'((exp_e.size() != len) && (abort_at < 0)));
        chk({name, ".cnt"}, 64'(sample_cnt), 64'(exp_e.size()));
        chk({name, ".otr_seen"}, 64'(otr_seen), 64'(otr_or));
    endtask

    initial begin
        int r_mode;
        int r_len;
        int r_decim;
        int r_level;
        int r_ext;
        int r_abort;

        fill_rand(0);
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("rst");
        step();
        step();
        rst_n = 1'b1;
        step();

        fill_ramp(100);
        run_cap("imm", 0, 4, 0, 0, -1, -1, -1, -1, 12);

        cfg_len   = '0;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        step();
        chk("len0.busy", 64'(busy), 64'd0);
        chk("len0.done", 64'(done), 64'd1);
        chk("len0.cnt", 64'(sample_cnt), 64'd4);

        fill_ramp(12'h7FC);
        run_cap("lvl", 1, 8, 0, 12'h800, -1, -1, -1, -1, 20);

        fill_rand(0);
        run_cap("dec2", 0, 3, 2, 0, -1, -1, -1, -1, 15);

        fill_rand(0);
        run_cap("ext", 2, 10, 1, 0, 5, 14, -1, -1, 40);

        fill_rand(0);
        run_cap("abort", 0, 10, 0, 0, -1, -1, 5, -1, 12);

        fill_rand(0);
        otrv[(e + 5) % SZ] = 1'b1;
        run_cap("otr", 0, 6, 1, 0, -1, -1, -1, -1, 16);

        fill_rand(0);
        run_cap("busy_start", 0, 8, 1, 0, -1, -1, -1, 4, 20);

        fill_rand(0);
        run_cap("abort_start", 0, 3, 0, 0, -1, -1, 8, 8, 10);

        fill_rand(3);
        run_cap("full", 3, 4096, 0, 0, -1, -1, -1, -1, 4100);

        fill_rand(0);
        run_cap("dmax", 0, 3, 65535, 0, -1, -1, 299, -1, 300);

        for (int r = 0; r < 8; r++) begin
            r_mode  = int'($urandom_range(0, 3));
            r_len   = int'($urandom_range(1, 20));
            r_decim = int'($urandom_range(0, 3));
            r_level = int'($urandom_range(0, 4095));
            r_ext   = int'($urandom_range(0, 30));
            r_abort = int'($urandom_range(20, 119));
            fill_rand(10);
            run_cap($sformatf("rnd%0d", r), r_mode, r_len, r_decim, r_level,
                    r_ext, -1, r_abort, -1, 120);
        end

        fill_rand(20);
        cfg_len       = 13'd100;
        cfg_decim     = '0;
        cfg_trig_mode = 2'd0;
        cfg_start     = 1'b1;
        step();
        cfg_start = 1'b0;
        step();
        step();
        step();
        chk("rst2.inflight", 64'(wr_en), 64'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst2");
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("rst2.after_wr_en", 64'(wr_en), 64'd0);
        chk("rst2.after_busy", 64'(busy), 64'd0);
        chk("rst2.after_cnt", 64'(sample_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Sequences one ADC acquisition run into the capture BRAM. Software arms a capture with a length, a decimation factor and a trigger mode. The block waits for the trigger, then writes decimated 12-bit samples (with the over-range bit) to consecutive BRAM addresses from 0. It sits between the ADC pin interface and the BRAM write port and reports busy, done and over-range status to the register bank.

Parameters:
DATA_W, 12, ADC sample width
ADDR_W, 12, BRAM address width; max capture = 2**ADDR_W samples
DECIM_W, 16, width of the decimation register

Ports:
clk_i  in  1  ADC sample clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
adc_data  in  DATA_W  raw ADC sample
adc_otr  in  1  ADC over-range flag, aligned with adc_data
cfg_start  in  1  one-cycle pulse: latch config and arm
cfg_abort  in  1  one-cycle pulse: stop the run, return to IDLE
cfg_len  in  ADDR_W+1  number of samples to write, 1..2**ADDR_W
cfg_decim  in  DECIM_W  write every (cfg_decim+1)th sample
cfg_trig_mode  in  2  0=immediate, 1=level rising crossing, 2=external edge, 3=immediate
cfg_trig_level  in  DATA_W  threshold for mode 1
ext_trig  in  1  asynchronous external trigger
wr_en  out  1  BRAM write enable
wr_addr  out  ADDR_W  BRAM write address
wr_data  out  32  {19'b0, otr, sample}
busy  out  1  high in ARMED or CAPTURE
done  out  1  run completed; sticky
otr_seen  out  1  sticky: any written sample had otr=1
sample_cnt  out  ADDR_W+1  samples written in the current or last run

Behaviour:
- Reset (rst_n low, async): state=IDLE. wr_en, wr_addr, wr_data, busy, done, otr_seen and sample_cnt are all 0. Input and sync registers are 0.
- Input stage: adc_data and adc_otr are registered once (adc_q, otr_q). prev_q holds the previous adc_q.
- ext_trig passes through a 2-flop synchronizer plus an edge register. The trigger event is the sync 0->1 edge.
- States:
  - IDLE: cfg_start with cfg_len!=0 -> latch len/decim/mode/level. Clear done, otr_seen, sample_cnt and the decimation counter. Go to ARMED. cfg_start with cfg_len==0 is ignored.
  - ARMED: on trigger -> CAPTURE. Mode 0/3 triggers on the first ARMED cycle. Mode 1 triggers when prev_q < level && adc_q >= level (unsigned). Mode 2 triggers on the ext edge.
  - CAPTURE: the decimation counter counts 0..decim and wraps to 0. A write occurs on every cycle where the counter is 0. The counter is 0 in the trigger cycle, so the triggering adc_q is the first sample written. After the write with sample_cnt+1 == len -> DONE.
  - DONE: done=1 and busy=0. Hold until the next accepted cfg_start, which moves to ARMED.
- Write timing: the write is registered. A sample is on the adc_data pins at edge N. It is written with wr_en=1 in cycle N+2 (2-cycle pin-to-port latency). wr_addr = sample_cnt before increment, so addresses run 0,1,...,len-1. wr_en is a single-cycle pulse per sample.
- otr_seen is set when a written sample has otr=1.
- cfg_abort in any state -> IDLE next cycle. Any pending write is suppressed. done is unchanged (stays 0 if the run was in progress). sample_cnt is kept.
- cfg_start while busy is ignored. If cfg_start and cfg_abort arrive in the same cycle, abort wins.
- cfg_len = 2**ADDR_W: the last address is all-ones. wr_addr never wraps within a run.
- cfg_decim = 0: a write every cycle. cfg_decim = max: the counter wraps at 2**DECIM_W-1.
- Reset asserted mid-run: immediate return to the reset values above, with no partial write completing.

Decomposition:
- Package adc_cap_pkg: state enum (IDLE, ARMED, CAPTURE, DONE), trigger-mode constants (TRIG_IMM=0, TRIG_LEVEL=1, TRIG_EXT=2), default widths.
- Sub-module adc_trig_detect: contains the ext_trig synchronizer, the edge detector and the level-crossing compare. It outputs a one-cycle trig pulse when enabled by ARMED.

Test Plan:
- Immediate mode, len=4, decim=0, ramp input 100,101,... -> 4 consecutive wr_en cycles; addrs 0..3; data holds the first 4 samples after arming; done=1; sample_cnt=4.
- Level mode, level=0x800, ramp from 0x7FC -> first write data=0x800 at addr 0; no writes before it; len=8 ends with addr 7.
- decim=2, len=3, immediate -> wr_en every 3rd cycle; written samples are s0, s3, s6; done after the third write.
- External mode: pulse ext_trig 3 cycles wide -> exactly one trigger, about 3 cycles after the edge; a second pulse during CAPTURE has no effect.
- Abort during CAPTURE after 5 of 10 writes -> no more wr_en; busy=0, done=0, sample_cnt=5. A new start clears sample_cnt and restarts at addr 0.
- adc_otr=1 on the 2nd written sample -> wr_data bit12=1 at addr 1; otr_seen=1 sticky until the next start. Reset asserted mid-run -> all outputs 0 immediately.
